sky130_rom_arbiter: RTL and testbench

Parametrised multi-channel read front-end for one OpenROM ROM macro (the 8x1024 instance or any other width and depth). It accepts independent read requests from NUM_CH clients and serialises them onto the macro with a round-robin arbiter. It tracks in-flight reads through a latency-matched pipeline and returns registered data with a one-hot per-channel valid. An optional same-address reuse path suppresses redundant macro accesses to save power.

---
 rtl/sky130_rom_pkg.sv | 16 +
 rtl/sky130_rom_rr_arb.sv | 25 ++
 rtl/sky130_rom_arbiter.sv | 74 +++++++
 tb/tb_sky130_rom_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_rom_pkg.sv
// sky130_rom_pkg: shared types and constants for the OpenROM multi-channel read front-end.
package sky130_rom_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 4;
  localparam int CH_ID_W = 3;
  typedef struct packed {
    logic vld;
    logic [CH_ID_W-1:0] ch;
    logic reuse;
  } pipe_entry_t;
  function automatic logic [CH_ID_W-1:0] next_ch(input logic [CH_ID_W-1:0] ch, input int num_ch);
    return (int'(ch) + 1 == num_ch) ? '0 : ch + 1'b1;
  endfunction
endpackage

// File: rtl/sky130_rom_rr_arb.sv
// sky130_rom_rr_arb: round-robin arbiter, winner is the nearest requester at or after ptr.
module sky130_rom_rr_arb
  import sky130_rom_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  req,
  output logic [NUM_CH-1:0]  gnt,
  output logic [CH_ID_W-1:0] idx,
  output logic               win
);
  logic [CH_ID_W-1:0] ptr;
  always_comb begin
    idx = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_CH]) idx = CH_ID_W'((int'(ptr) + k) % NUM_CH);
    win = rst_n && |req;
    gnt = win ? NUM_CH'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (win) ptr <= next_ch(idx, NUM_CH);
endmodule

// File: rtl/sky130_rom_arbiter.sv
// sky130_rom_arbiter: serialises NUM_CH read clients onto one ROM macro with a
// latency-matched completion pipeline and optional same-address reuse.
module sky130_rom_arbiter
  import sky130_rom_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_CH      = 4,
  parameter int ROM_LATENCY = 1,
  parameter int REUSE_EN    = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rom_cs,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_dout,
  output logic [CNT_WIDTH-1:0]         access_cnt
);
  localparam int LAT = ROM_LATENCY < ROM_LAT_MIN ? ROM_LAT_MIN :
                       ROM_LATENCY > ROM_LAT_MAX ? ROM_LAT_MAX : ROM_LATENCY;
  logic [CH_ID_W-1:0]  idx;
  logic                win, hit, last_vld;
  logic [ADDR_WIDTH-1:0] win_addr, last_addr;
  pipe_entry_t         pipe [LAT];
  pipe_entry_t         tail;
  sky130_rom_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .idx  (idx),
    .win  (win)
  );
  always_comb begin
    win_addr = ch_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
    hit      = (REUSE_EN != 0) && win && last_vld && win_addr == last_addr;
    rom_cs   = win && !hit;
    rom_addr = rom_cs ? win_addr : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_vld   <= 1'b0;
      last_addr  <= '0;
      access_cnt <= '0;
    end else if (rom_cs) begin
      last_vld   <= 1'b1;
      last_addr  <= rom_addr;
      access_cnt <= access_cnt + CNT_WIDTH'(access_cnt != '1);
    end
  // Stage LAT-1 lines up with the cycle in which rom_dout is valid for that entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{vld: win, ch: idx, reuse: hit};
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  assign tail = pipe[LAT-1];
  // Reuse entries keep rdata: in-order completion leaves the last real read's data there.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= tail.vld ? NUM_CH'(1) << tail.ch : '0;
      if (tail.vld && !tail.reuse) rdata <= rom_dout;
    end
endmodule

// File: tb/tb_sky130_rom_arbiter.sv
// tb_sky130_rom_arbiter: three DUT variants (lat1/reuse, lat1/no-reuse, lat3/reuse)
// driven in parallel and checked against a cycle-scheduled reference model.
module tb_sky130_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [39:0] ch_addr;
  logic [3:0]  gnt_o [3];
  logic [3:0]  rvalid_o [3];
  logic [7:0]  rdata_o [3];
  logic        cs_o [3];
  logic [9:0]  ra_o [3];
  logic [15:0] cnt_o [3];
  logic [7:0]  mem [1024];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic int lat_of(input int k);
    return k == 2 ? 3 : 1;
  endfunction
  function automatic int reu_of(input int k);
    return k == 1 ? 0 : 1;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] sh [4];
    always @(posedge clk) begin
      sh[0] <= cs_o[g] ? mem[ra_o[g]] : 8'($urandom);
      for (int i = 1; i < 4; i++) sh[i] <= sh[i-1];
    end
    sky130_rom_arbiter #(
      .DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_CH(4),
      .ROM_LATENCY(lat_of(g)), .REUSE_EN(reu_of(g)), .CNT_WIDTH(16)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .ch_addr   (ch_addr),
      .gnt       (gnt_o[g]),
      .rvalid    (rvalid_o[g]),
      .rdata     (rdata_o[g]),
      .rom_cs    (cs_o[g]),
      .rom_addr  (ra_o[g]),
      .rom_dout  (sh[lat_of(g)-1]),
      .access_cnt(cnt_o[g])
    );
  end
  // Reference model: completions are booked into a per-cycle table at issue time.
  int         cyc = 0;
  int         m_ptr;
  logic       m_lv [3];
  logic [9:0] m_la [3];
  int         m_cnt [3];
  logic [2:0] s_ch [3][16];
  logic [7:0] s_d [3][16];
  int         e_idx;
  logic [9:0] e_addr;
  logic [3:0] e_gnt;
  logic       e_cs [3];
  logic [3:0] e_rv [3];
  logic [7:0] e_rd [3];
  always_comb begin
    e_idx = -1;
    for (int i = 0; i < 4; i++)
      if (req[i] && (e_idx < 0 || (i - m_ptr + 4) % 4 < (e_idx - m_ptr + 4) % 4)) e_idx = i;
    e_gnt  = (rst_n && e_idx >= 0) ? 4'(1 << e_idx) : 4'b0;
    e_addr = e_idx >= 0 ? ch_addr[e_idx*10 +: 10] : 10'd0;
    for (int k = 0; k < 3; k++) begin
      e_cs[k] = rst_n && e_idx >= 0 && !(reu_of(k) != 0 && m_lv[k] && m_la[k] == e_addr);
      e_rv[k] = (rst_n && s_ch[k][cyc%16] != 0) ? 4'(1 << (int'(s_ch[k][cyc%16]) - 1)) : 4'b0;
      e_rd[k] = s_d[k][cyc%16];
    end
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ptr <= 0;
      for (int k = 0; k < 3; k++) begin
        m_lv[k] <= 1'b0;
        m_la[k] <= '0;
        m_cnt[k] <= 0;
        for (int s = 0; s < 16; s++) s_ch[k][s] <= '0;
      end
    end else begin
      if (e_idx >= 0) m_ptr <= (e_idx + 1) % 4;
      for (int k = 0; k < 3; k++) begin
        s_ch[k][cyc%16] <= '0;
        if (e_idx >= 0) begin
          s_ch[k][(cyc+lat_of(k)+1)%16] <= 3'(e_idx + 1);
          s_d[k][(cyc+lat_of(k)+1)%16]  <= mem[e_addr];
        end
        if (e_cs[k]) begin
          m_lv[k]  <= 1'b1;
          m_la[k]  <= e_addr;
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
    cyc <= cyc + 1;
  end
  task automatic drive(input logic [3:0] r, input logic [39:0] a);
    @(posedge clk);
    #1;
    req = r;
    ch_addr = a;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'h0;
    ch_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gnt_o[k], rvalid_o[k], rdata_o[k], cs_o[k], ra_o[k], cnt_o[k]} !== 43'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got gnt=%b rv=%b rd=%h cs=%b ra=%h cnt=%0d exp all zero",
                 k, gnt_o[k], rvalid_o[k], rdata_o[k], cs_o[k], ra_o[k], cnt_o[k]);
      end
    end
    req = 4'hF;
    #1;
    checks++;
    if (gnt_o[0] !== 4'b0 || cs_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt_forced got gnt=%b cs=%b exp 0000/0", gnt_o[0], cs_o[0]);
    end
    req = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_all_four;
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 8; c++) begin
      drive(r, {10'h013, 10'h012, 10'h011, 10'h010});
      if (c < 4) begin
        checks++;
        if (gnt_o[0] !== 4'(1 << c)) begin
          failures++;
          $display("FAIL all4_gnt c=%0d got=%b exp=%b", c, gnt_o[0], 4'(1 << c));
        end
      end
      if (c >= 2 && c < 6) begin
        checks++;
        if (rvalid_o[0] !== 4'(1 << (c - 2)) || rdata_o[0] !== mem[16 + c - 2]) begin
          failures++;
          $display("FAIL all4_rvalid c=%0d got rv=%b rd=%h exp rv=%b rd=%h",
                   c, rvalid_o[0], rdata_o[0], 4'(1 << (c - 2)), mem[16 + c - 2]);
        end
      end
      r = r & ~e_gnt;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cnt_o[k] !== 16'd4) begin
        failures++;
        $display("FAIL all4_cnt dut%0d got=%0d exp=4", k, cnt_o[k]);
      end
    end
  endtask
  task automatic test_single;
    drive(4'b0001, {30'd0, 10'h005});
    checks++;
    if (gnt_o[0] !== 4'b0001 || cs_o[0] !== 1'b1 || ra_o[0] !== 10'h005) begin
      failures++;
      $display("FAIL single_issue got gnt=%b cs=%b ra=%h exp 0001/1/005", gnt_o[0], cs_o[0], ra_o[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(4'b0, '0);
      checks += 2;
      if (rvalid_o[0] !== (i == 2 ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL single_rv_lat1 T+%0d got=%b", i, rvalid_o[0]);
      end
      if (rvalid_o[2] !== (i == 4 ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL single_rv_lat3 T+%0d got=%b", i, rvalid_o[2]);
      end
      if (i == 2) begin
        checks++;
        if (rdata_o[0] !== mem[5]) begin
          failures++;
          $display("FAIL single_rd_lat1 got=%h exp=%h", rdata_o[0], mem[5]);
        end
      end
      if (i == 4) begin
        checks++;
        if (rdata_o[2] !== mem[5]) begin
          failures++;
          $display("FAIL single_rd_lat3 got=%h exp=%h", rdata_o[2], mem[5]);
        end
      end
    end
  endtask
  task automatic test_reuse;
    int b0, b1;
    b0 = m_cnt[0];
    b1 = m_cnt[1];
    drive(4'b0010, {20'd0, 10'h3FF, 10'd0});
    checks++;
    if (gnt_o[0] !== 4'b0010 || cs_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL reuse_first got gnt=%b cs=%b exp 0010/1", gnt_o[0], cs_o[0]);
    end
    drive(4'b0100, {10'd0, 10'h3FF, 20'd0});
    checks++;
    if (gnt_o[0] !== 4'b0100 || cs_o[0] !== 1'b0 || cs_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL reuse_hit got gnt=%b cs0=%b cs1=%b exp 0100/0/1", gnt_o[0], cs_o[0], cs_o[1]);
    end
    drive(4'b0, '0);
    drive(4'b0, '0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rvalid_o[k] !== 4'b0100 || rdata_o[k] !== mem[1023]) begin
        failures++;
        $display("FAIL reuse_data dut%0d got rv=%b rd=%h exp rv=0100 rd=%h", k, rvalid_o[k], rdata_o[k], mem[1023]);
      end
    end
    drive(4'b0, '0);
    checks += 2;
    if (int'(cnt_o[0]) !== b0 + 1) begin
      failures++;
      $display("FAIL reuse_cnt_en got=%0d exp=%0d", cnt_o[0], b0 + 1);
    end
    if (int'(cnt_o[1]) !== b1 + 2) begin
      failures++;
      $display("FAIL reuse_cnt_dis got=%0d exp=%0d", cnt_o[1], b1 + 2);
    end
  endtask
  task automatic test_fairness;
    logic [3:0] prev;
    logic       seen3;
    seen3 = 1'b0;
    prev = 4'b0;
    for (int c = 0; c < 6; c++) begin
      drive(4'b1001, {10'h030, 20'd0, 10'h020});
      if (c < 2 && gnt_o[0] == 4'b1000) seen3 = 1'b1;
      checks++;
      if (gnt_o[0] !== e_gnt) begin
        failures++;
        $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, gnt_o[0], e_gnt);
      end
      if (c > 0) begin
        checks++;
        if (gnt_o[0] === prev) begin
          failures++;
          $display("FAIL fair_alternate c=%0d got=%b repeated", c, gnt_o[0]);
        end
      end
      prev = gnt_o[0];
    end
    checks++;
    if (!seen3) begin
      failures++;
      $display("FAIL fair_ch3_wait got no ch3 grant within 2 cycles exp one");
    end
    repeat (5) drive(4'b0, '0);
  endtask
  task automatic test_back_to_back;
    logic [9:0] a [4];
    int gq[$];
    logic [9:0] aq[$];
    int ng, pulses;
    logic [3:0] r;
    ng = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) a[i] = 10'($urandom);
    for (int c = 0; c < 16; c++) begin
      r = ng < 8 ? 4'hF : 4'h0;
      drive(r, {a[3], a[2], a[1], a[0]});
      if (e_idx >= 0) begin
        gq.push_back(e_idx);
        aq.push_back(a[e_idx]);
        a[e_idx] = 10'($urandom);
        ng++;
      end
      checks++;
      if (rvalid_o[2] !== e_rv[2]) begin
        failures++;
        $display("FAIL b2b_rv c=%0d got=%b exp=%b", c, rvalid_o[2], e_rv[2]);
      end
      if (rvalid_o[2] != 0 && gq.size() > 0) begin
        pulses++;
        checks++;
        if (rvalid_o[2] !== 4'(1 << gq[0]) || rdata_o[2] !== mem[aq[0]]) begin
          failures++;
          $display("FAIL b2b_order c=%0d got rv=%b rd=%h exp rv=%b rd=%h",
                   c, rvalid_o[2], rdata_o[2], 4'(1 << gq[0]), mem[aq[0]]);
        end
        void'(gq.pop_front());
        void'(aq.pop_front());
      end
    end
    checks++;
    if (pulses !== 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=8", pulses);
    end
  endtask
  task automatic test_random;
    logic [3:0] r;
    logic [9:0] a [4];
    r = 4'h0;
    for (int i = 0; i < 4; i++) a[i] = 10'h100;
    for (int c = 0; c < 400; c++) begin
      drive(r, {a[3], a[2], a[1], a[0]});
      for (int k = 0; k < 3; k++) begin
        checks += 4;
        if (gnt_o[k] !== e_gnt) begin
          failures++;
          $display("FAIL rand_gnt dut%0d cyc=%0d got=%b exp=%b", k, cyc, gnt_o[k], e_gnt);
        end
        if (cs_o[k] !== e_cs[k]) begin
          failures++;
          $display("FAIL rand_cs dut%0d cyc=%0d got=%b exp=%b", k, cyc, cs_o[k], e_cs[k]);
        end
        if (rvalid_o[k] !== e_rv[k]) begin
          failures++;
          $display("FAIL rand_rv dut%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid_o[k], e_rv[k]);
        end
        if (cnt_o[k] !== 16'(m_cnt[k])) begin
          failures++;
          $display("FAIL rand_cnt dut%0d cyc=%0d got=%0d exp=%0d", k, cyc, cnt_o[k], m_cnt[k]);
        end
        if (e_cs[k]) begin
          checks++;
          if (ra_o[k] !== e_addr) begin
            failures++;
            $display("FAIL rand_addr dut%0d cyc=%0d got=%h exp=%h", k, cyc, ra_o[k], e_addr);
          end
        end
        if (e_rv[k] != 0) begin
          checks++;
          if (rdata_o[k] !== e_rd[k]) begin
            failures++;
            $display("FAIL rand_rd dut%0d cyc=%0d got=%h exp=%h", k, cyc, rdata_o[k], e_rd[k]);
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (!r[i] || e_gnt[i]) begin
          r[i] = c < 392 && $urandom_range(0, 2) != 0;
          a[i] = 10'h100 + 10'($urandom_range(0, 5));
        end
    end
  endtask
  task automatic test_reset_midflight;
    drive(4'b0001, {30'd0, 10'h077});
    checks++;
    if (gnt_o[0] !== 4'b0001) begin
      failures++;
      $display("FAIL mid_grant got=%b exp=0001", gnt_o[0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = 4'b0110;
    ch_addr = {10'd0, 10'h044, 10'h033, 10'd0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({gnt_o[k], rvalid_o[k], rdata_o[k], cs_o[k], ra_o[k], cnt_o[k]} !== 43'd0) begin
          failures++;
          $display("FAIL mid_reset_outputs dut%0d c=%0d got gnt=%b rv=%b rd=%h cs=%b cnt=%0d exp all zero",
                   k, c, gnt_o[k], rvalid_o[k], rdata_o[k], cs_o[k], cnt_o[k]);
        end
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o[0] !== 4'b0010) begin
      failures++;
      $display("FAIL mid_first_grant got=%b exp=0010", gnt_o[0]);
    end
    for (int c = 1; c <= 6; c++) begin
      drive(c == 1 ? 4'b0100 : 4'b0000, {10'd0, 10'h044, 10'h033, 10'd0});
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rvalid_o[k] !== (c == lat_of(k) + 1 ? 4'b0010 : c == lat_of(k) + 2 ? 4'b0100 : 4'b0000)) begin
          failures++;
          $display("FAIL mid_post_rv dut%0d c=%0d got=%b", k, c, rvalid_o[k]);
        end
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    req = 4'h0;
    ch_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    test_reset;
    test_all_four;
    test_single;
    test_reuse;
    test_fairness;
    test_back_to_back;
    test_random;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
